tlb_attri_array: RTL and testbench

TLB_ATTRI_ARRAY -- requirements
Module: tlb_attri_array

---
 rtl/tlb_pkg.sv | 28 ++
 rtl/tlb_attri_array_if.sv | 55 +++++
 rtl/tlb_repl.sv | 96 +++++++++
 rtl/tlb_attri_array.sv | 138 +++++++++++++
 tb/tb_tlb_attri_array.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
// ----------------------------------------------------------------------------
// tlb_pkg
// Shared types for the TLB attribute array: refill FSM state encoding and the
// PTE flag bundle delivered by the page-table walker, plus the leaf-PTE test.
// No ports (package).
// ----------------------------------------------------------------------------
package tlb_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } tlb_state_e;

    typedef struct packed {
        logic v;
        logic u;
        logic w;
        logic x;
        logic r;
        logic d;
    } pte_flags_t;

    // A PTE is a leaf when valid and it grants read, or execute without write.
    function automatic logic pte_is_leaf(pte_flags_t p);
        return p.v & (p.r | (p.x & ~p.w));
    endfunction

endpackage

// File: rtl/tlb_attri_array_if.sv
// ----------------------------------------------------------------------------
// tlb_attri_array_if
// Bundles the refill handshake, PTW response, PMA attributes, lookup hit mask
// and the registered attribute vectors of tlb_attri_array.
// Modports:
//   slave  - the attribute array (drives miss_ready, arrays, refill_waddr)
//   master - the requester / PTW side (drives everything else)
// ----------------------------------------------------------------------------
interface tlb_attri_array_if #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
);
    logic               miss_valid;
    logic               miss_ready;
    logic               io_ptw_resp_valid;
    logic               io_ptw_resp_bits_pte_v;
    logic               io_ptw_resp_bits_pte_u;
    logic               io_ptw_resp_bits_pte_w;
    logic               io_ptw_resp_bits_pte_x;
    logic               io_ptw_resp_bits_pte_r;
    logic               io_ptw_resp_bits_pte_d;
    logic               io_ptw_invalidate;
    logic               prot_w;
    logic               prot_x;
    logic               prot_r;
    logic               cacheable;
    logic [ENTRIES-1:0] hit_mask;
    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] u_array;
    logic [ENTRIES-1:0] sw_array;
    logic [ENTRIES-1:0] sx_array;
    logic [ENTRIES-1:0] sr_array;
    logic [ENTRIES-1:0] xr_array;
    logic [ENTRIES-1:0] cash_array;
    logic [ENTRIES-1:0] dirty_array;
    logic [IDX_W-1:0]   refill_waddr;

    modport slave (
        input  miss_valid, io_ptw_resp_valid,
        input  io_ptw_resp_bits_pte_v, io_ptw_resp_bits_pte_u, io_ptw_resp_bits_pte_w,
        input  io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_r, io_ptw_resp_bits_pte_d,
        input  io_ptw_invalidate, prot_w, prot_x, prot_r, cacheable, hit_mask,
        output miss_ready, valid, u_array, sw_array, sx_array, sr_array, xr_array,
        output cash_array, dirty_array, refill_waddr
    );

    modport master (
        output miss_valid, io_ptw_resp_valid,
        output io_ptw_resp_bits_pte_v, io_ptw_resp_bits_pte_u, io_ptw_resp_bits_pte_w,
        output io_ptw_resp_bits_pte_x, io_ptw_resp_bits_pte_r, io_ptw_resp_bits_pte_d,
        output io_ptw_invalidate, prot_w, prot_x, prot_r, cacheable, hit_mask,
        input  miss_ready, valid, u_array, sw_array, sx_array, sr_array, xr_array,
        input  cash_array, dirty_array, refill_waddr
    );
endinterface

// File: rtl/tlb_repl.sv
// ----------------------------------------------------------------------------
// tlb_repl
// Replacement state for the TLB attribute array.
//   TLB_ATTRI_PLRU_EN defined   : tree pseudo-LRU (ENTRIES-1 bits), touched by
//                                 hit_mask and then by the refill write.
//   TLB_ATTRI_PLRU_EN undefined : IDX_W round-robin pointer, advanced on each
//                                 accepted miss that used it; hits ignored.
// Ports:
//   clk, reset     - clock, async active-high reset
//   i_hit_mask     - one-hot lookup hit
//   i_alloc        - accepted miss that took the victim from this block
//   i_refill_we    - refill write this cycle, to entry i_refill_idx
//   o_victim       - replacement victim index
// ----------------------------------------------------------------------------
module tlb_repl #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ENTRIES-1:0] i_hit_mask,
    input  logic               i_alloc,
    input  logic               i_refill_we,
    input  logic [IDX_W-1:0]   i_refill_idx,
    output logic [IDX_W-1:0]   o_victim
);

`ifdef TLB_ATTRI_PLRU_EN
    // Heap-ordered tree: node n has children 2n and 2n+1; a bit of 0 points the
    // victim search left, 1 points it right.
    logic [ENTRIES-1:1] r_tree;
    logic [ENTRIES-1:1] w_tree_nxt;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_unused;

    assign w_unused = i_alloc;

    // Point every node on the path to idx away from it.
    function automatic logic [ENTRIES-1:1] touch(logic [ENTRIES-1:1] t,
                                                 logic [IDX_W-1:0]   idx);
        int unsigned node;
        node = 1;
        for (int lvl = 0; lvl < int'(IDX_W); lvl++) begin
            t[node] = ~idx[int'(IDX_W) - 1 - lvl];
            node    = (node << 1) | 32'(idx[int'(IDX_W) - 1 - lvl]);
        end
        return t;
    endfunction

    always_comb begin
        w_hit_idx = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (i_hit_mask[i]) w_hit_idx = IDX_W'(i);
        end
    end

    // Hit first, refill second, so the refill path wins on shared nodes.
    always_comb begin
        w_tree_nxt = r_tree;
        if (|i_hit_mask) w_tree_nxt = touch(w_tree_nxt, w_hit_idx);
        if (i_refill_we) w_tree_nxt = touch(w_tree_nxt, i_refill_idx);
    end

    always_comb begin
        int unsigned node;
        node = 1;
        for (int lvl = 0; lvl < int'(IDX_W); lvl++) begin
            node = (node << 1) | 32'(r_tree[node]);
        end
        o_victim = IDX_W'(node - ENTRIES);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tree <= '0;
        end else begin
            r_tree <= w_tree_nxt;
        end
    end
`else
    logic [IDX_W-1:0] r_ptr;
    logic             w_unused;

    assign w_unused = ^{i_hit_mask, i_refill_we, i_refill_idx};
    assign o_victim = r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_alloc) begin
            r_ptr <= r_ptr + IDX_W'(1);
        end
    end
`endif

endmodule

// File: rtl/tlb_attri_array.sv
// ----------------------------------------------------------------------------
// tlb_attri_array
// Per-entry TLB permission/attribute store with a single-outstanding refill.
// A miss (IDLE only) latches a victim index; the next PTW response writes all
// attribute bits of that entry. An invalidate clears every valid bit and, if a
// refill is pending, marks it stale so its write leaves the entry invalid.
// Replacement policy lives in tlb_repl; define TLB_ATTRI_PLRU_EN for tree
// pseudo-LRU, otherwise round-robin.
// Ports:
//   clk, reset - clock, async active-high reset
//   bus        - tlb_attri_array_if.slave (handshake, PTW response, arrays)
// ----------------------------------------------------------------------------
module tlb_attri_array
    import tlb_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input logic               clk,
    input logic               reset,
    tlb_attri_array_if.slave  bus
);

    tlb_state_e         r_state;
    tlb_state_e         w_state_nxt;
    logic               r_stale;
    logic [IDX_W-1:0]   r_waddr;
    logic [ENTRIES-1:0] r_valid, r_u, r_sw, r_sx, r_sr, r_xr, r_cash, r_dirty;

    pte_flags_t         w_pte;
    logic               w_leaf;
    logic               w_accept;
    logic               w_resp;
    logic               w_inv_found;
    logic [IDX_W-1:0]   w_inv_idx;
    logic [IDX_W-1:0]   w_repl_victim;
    logic [IDX_W-1:0]   w_victim;

    assign w_pte = {bus.io_ptw_resp_bits_pte_v, bus.io_ptw_resp_bits_pte_u,
                    bus.io_ptw_resp_bits_pte_w, bus.io_ptw_resp_bits_pte_x,
                    bus.io_ptw_resp_bits_pte_r, bus.io_ptw_resp_bits_pte_d};
    assign w_leaf   = pte_is_leaf(w_pte);
    assign w_accept = bus.miss_valid & (r_state == StIdle);
    assign w_resp   = bus.io_ptw_resp_valid & (r_state == StWait);

    // Lowest-index invalid entry; scanning downward leaves the lowest match.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_idx   = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_inv_found = 1'b1;
                w_inv_idx   = IDX_W'(i);
            end
        end
    end

    assign w_victim = w_inv_found ? w_inv_idx : w_repl_victim;

    tlb_repl #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_repl (
        .clk          (clk),
        .reset        (reset),
        .i_hit_mask   (bus.hit_mask),
        .i_alloc      (w_accept & ~w_inv_found),
        .i_refill_we  (w_resp),
        .i_refill_idx (r_waddr),
        .o_victim     (w_repl_victim)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (bus.miss_valid) w_state_nxt = StWait;
            StWait:  if (bus.io_ptw_resp_valid) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_stale <= 1'b0;
            r_waddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_waddr <= w_victim;
                r_stale <= 1'b0;
            end else if ((r_state == StWait) && bus.io_ptw_invalidate) begin
                r_stale <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_u     <= '0;
            r_sw    <= '0;
            r_sx    <= '0;
            r_sr    <= '0;
            r_xr    <= '0;
            r_cash  <= '0;
            r_dirty <= '0;
        end else begin
            if (w_resp) begin
                r_u[r_waddr]     <= w_pte.u;
                r_sw[r_waddr]    <= w_leaf & w_pte.w & bus.prot_w;
                r_sx[r_waddr]    <= w_leaf & w_pte.x & bus.prot_x;
                r_sr[r_waddr]    <= w_leaf & w_pte.r & bus.prot_r;
                r_xr[r_waddr]    <= w_leaf & w_pte.x & bus.prot_r;
                r_cash[r_waddr]  <= bus.cacheable;
                r_dirty[r_waddr] <= w_pte.d;
            end
            // Invalidate beats a same-cycle refill; a stale refill stays invalid.
            if (bus.io_ptw_invalidate) begin
                r_valid <= '0;
            end else if (w_resp) begin
                r_valid[r_waddr] <= ~r_stale;
            end
        end
    end

    assign bus.miss_ready   = (r_state == StIdle);
    assign bus.refill_waddr = r_waddr;
    assign bus.valid        = r_valid;
    assign bus.u_array      = r_u;
    assign bus.sw_array     = r_sw;
    assign bus.sx_array     = r_sx;
    assign bus.sr_array     = r_sr;
    assign bus.xr_array     = r_xr;
    assign bus.cash_array   = r_cash;
    assign bus.dirty_array  = r_dirty;

endmodule

// File: tb/tb_tlb_attri_array.sv
// ----------------------------------------------------------------------------
// tb_tlb_attri_array
// Self-checking bench for tlb_attri_array (ENTRIES = 8). Refill vectors come
// from a table; expected entry contents are queued when a response is driven
// and compared once the array has been written. Honours TLB_ATTRI_PLRU_EN.
// ----------------------------------------------------------------------------
module tb_tlb_attri_array;
    import tlb_pkg::*;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned IDX_W   = 3;

    // exp bit order: {valid, u, sw, sx, sr, xr, cash, dirty}
    typedef struct {
        pte_flags_t pte;
        logic       pw;
        logic       px;
        logic       pr;
        logic       cach;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [7:0]       bits;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    vec_t             vecs[8];
    sb_t              sb_q[$];
    logic [ENTRIES-1:0] m_valid;
    logic [IDX_W-1:0] m_ptr;
    logic [7:1]       m_tree;
    logic             m_stale;
    logic [IDX_W-1:0] m_widx;

    always #5 clk = ~clk;

    tlb_attri_array_if #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) bus ();

    tlb_attri_array #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] entry_bits(input int i);
        return {bus.valid[i], bus.u_array[i], bus.sw_array[i], bus.sx_array[i],
                bus.sr_array[i], bus.xr_array[i], bus.cash_array[i], bus.dirty_array[i]};
    endfunction

    function automatic logic [IDX_W-1:0] plru_victim();
        int n;
        n = 1;
        for (int l = 0; l < 3; l++) n = 2 * n + int'(m_tree[n]);
        return IDX_W'(n - 8);
    endfunction

    task automatic plru_touch(input logic [IDX_W-1:0] idx);
        m_tree[1]                  = ~idx[2];
        m_tree[2 + int'(idx[2])]   = ~idx[1];
        m_tree[4 + int'(idx[2:1])] = ~idx[0];
    endtask

    function automatic logic [IDX_W-1:0] model_victim();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (!m_valid[i]) return IDX_W'(i);
        end
`ifdef TLB_ATTRI_PLRU_EN
        return plru_victim();
`else
        return m_ptr;
`endif
    endfunction

    task automatic do_miss(input string name);
        logic [IDX_W-1:0] v;
        logic             used_ptr;
        v        = model_victim();
        used_ptr = &m_valid;
        check({name, " ready"}, 32'(bus.miss_ready), 32'd1);
        bus.miss_valid = 1'b1;
        tick();
        bus.miss_valid = 1'b0;
        if (used_ptr) m_ptr = m_ptr + IDX_W'(1);
        m_widx  = v;
        m_stale = 1'b0;
        check({name, " waddr"}, 32'(bus.refill_waddr), 32'(v));
        check({name, " busy"}, 32'(bus.miss_ready), 32'd0);
    endtask

    // hit_idx < 0 means no simultaneous lookup hit.
    task automatic do_resp(input vec_t vv, input string name, input int hit_idx);
        logic [7:0] e;
        sb_t        s;
        e = vv.exp;
        if (m_stale) e[7] = 1'b0;
        else         m_valid[m_widx] = 1'b1;
        sb_q.push_back('{idx: m_widx, bits: e});
        {bus.io_ptw_resp_bits_pte_v, bus.io_ptw_resp_bits_pte_u, bus.io_ptw_resp_bits_pte_w,
         bus.io_ptw_resp_bits_pte_x, bus.io_ptw_resp_bits_pte_r,
         bus.io_ptw_resp_bits_pte_d} = vv.pte;
        {bus.prot_w, bus.prot_x, bus.prot_r, bus.cacheable} = {vv.pw, vv.px, vv.pr, vv.cach};
        bus.hit_mask          = (hit_idx >= 0) ? ENTRIES'(1) << hit_idx : '0;
        bus.io_ptw_resp_valid = 1'b1;
        tick();
        bus.io_ptw_resp_valid = 1'b0;
        bus.hit_mask          = '0;
`ifdef TLB_ATTRI_PLRU_EN
        if (hit_idx >= 0) plru_touch(IDX_W'(hit_idx));
        plru_touch(m_widx);
`endif
        s = sb_q.pop_front();
        check({name, " entry"}, 32'(entry_bits(int'(s.idx))), 32'(s.bits));
        check({name, " valid"}, 32'(bus.valid), 32'(m_valid));
    endtask

    task automatic hit(input int idx);
        bus.hit_mask = ENTRIES'(1) << idx;
        tick();
        bus.hit_mask = '0;
`ifdef TLB_ATTRI_PLRU_EN
        plru_touch(IDX_W'(idx));
`endif
    endtask

    task automatic check_all_zero(input string name);
        check({name, " valid"}, 32'(bus.valid), 32'd0);
        check({name, " u"},     32'(bus.u_array), 32'd0);
        check({name, " sw"},    32'(bus.sw_array), 32'd0);
        check({name, " sx"},    32'(bus.sx_array), 32'd0);
        check({name, " sr"},    32'(bus.sr_array), 32'd0);
        check({name, " xr"},    32'(bus.xr_array), 32'd0);
        check({name, " cash"},  32'(bus.cash_array), 32'd0);
        check({name, " dirty"}, 32'(bus.dirty_array), 32'd0);
        check({name, " waddr"}, 32'(bus.refill_waddr), 32'd0);
        check({name, " ready"}, 32'(bus.miss_ready), 32'd1);
    endtask

    initial begin
        int w;
        //          pte {v,u,w,x,r,d}  pw    px    pr    cach  exp {vl,u,sw,sx,sr,xr,c,d}
        vecs[0] = '{pte: 6'b111011, pw: 1'b1, px: 1'b0, pr: 1'b1, cach: 1'b1, exp: 8'b1110_1011};
        vecs[1] = '{pte: 6'b101000, pw: 1'b1, px: 1'b1, pr: 1'b1, cach: 1'b0, exp: 8'b1000_0000};
        vecs[2] = '{pte: 6'b100100, pw: 1'b1, px: 1'b1, pr: 1'b1, cach: 1'b1, exp: 8'b1001_0110};
        vecs[3] = '{pte: 6'b111101, pw: 1'b1, px: 1'b1, pr: 1'b1, cach: 1'b0, exp: 8'b1100_0001};
        vecs[4] = '{pte: 6'b011110, pw: 1'b1, px: 1'b1, pr: 1'b1, cach: 1'b1, exp: 8'b1100_0010};
        vecs[5] = '{pte: 6'b101111, pw: 1'b0, px: 1'b1, pr: 1'b0, cach: 1'b1, exp: 8'b1001_0011};
        vecs[6] = '{pte: 6'b110110, pw: 1'b1, px: 1'b0, pr: 1'b1, cach: 1'b0, exp: 8'b1100_1100};
        vecs[7] = '{pte: 6'b101010, pw: 1'b1, px: 1'b1, pr: 1'b0, cach: 1'b0, exp: 8'b1010_0000};

        reset                      = 1'b1;
        bus.miss_valid             = 1'b0;
        bus.io_ptw_resp_valid      = 1'b0;
        bus.io_ptw_resp_bits_pte_v = 1'b0;
        bus.io_ptw_resp_bits_pte_u = 1'b0;
        bus.io_ptw_resp_bits_pte_w = 1'b0;
        bus.io_ptw_resp_bits_pte_x = 1'b0;
        bus.io_ptw_resp_bits_pte_r = 1'b0;
        bus.io_ptw_resp_bits_pte_d = 1'b0;
        bus.io_ptw_invalidate      = 1'b0;
        bus.prot_w                 = 1'b0;
        bus.prot_x                 = 1'b0;
        bus.prot_r                 = 1'b0;
        bus.cacheable              = 1'b0;
        bus.hit_mask               = '0;
        m_valid = '0;
        m_ptr   = '0;
        m_tree  = '0;
        m_stale = 1'b0;
        m_widx  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Response while IDLE must be dropped.
        {bus.io_ptw_resp_bits_pte_v, bus.io_ptw_resp_bits_pte_u, bus.io_ptw_resp_bits_pte_d} = 3'b111;
        {bus.prot_w, bus.prot_x, bus.prot_r, bus.cacheable} = 4'hf;
        bus.io_ptw_resp_valid = 1'b1;
        tick();
        bus.io_ptw_resp_valid = 1'b0;
        check_all_zero("reset");

        // Fill all entries from the vector table; invalid entries go first.
        for (int i = 0; i < 8; i++) begin
            do_miss($sformatf("fill%0d", i));
            do_resp(vecs[i], $sformatf("fill%0d", i), -1);
        end

`ifdef TLB_ATTRI_PLRU_EN
        hit(0);
        do_miss("plru_after_hit0");
        check("plru victim not 0", 32'(bus.refill_waddr != '0), 32'd1);
        w = int'(m_widx);
        // Sibling hit in the same cycle as the refill: the refill leaf bit must win.
        do_resp(vecs[3], "plru_both", w ^ 1);
        hit(w ^ 2);
        hit(w ^ 3);
        for (int k = 4; k < 8; k++) hit(w ^ k);
        do_miss("plru_refill_wins");
        check("plru victim sibling", 32'(bus.refill_waddr), 32'(w ^ 1));
        do_resp(vecs[4], "plru_fill", -1);
`else
        hit(5);
        do_miss("rr9");
        check("rr9 victim", 32'(bus.refill_waddr), 32'd0);
        do_resp(vecs[0], "rr9", -1);
        do_miss("rr10");
        check("rr10 victim", 32'(bus.refill_waddr), 32'd1);
        do_resp(vecs[2], "rr10", -1);
`endif

        // Invalidate while a refill is pending; a second miss must be ignored.
        do_miss("inv");
        w = int'(m_widx);
        bus.miss_valid        = 1'b1;
        bus.io_ptw_invalidate = 1'b1;
        tick();
        bus.io_ptw_invalidate = 1'b0;
        bus.miss_valid        = 1'b0;
        m_valid = '0;
        m_stale = 1'b1;
        check("inv valid cleared", 32'(bus.valid), 32'd0);
        check("inv miss ignored", 32'(bus.refill_waddr), 32'(w));
        check("inv still waiting", 32'(bus.miss_ready), 32'd0);
        do_resp(vecs[6], "inv_resp", -1);

        // Next refill is no longer stale.
        do_miss("post_inv");
        do_resp(vecs[7], "post_inv", -1);

        // Reset while waiting abandons the refill.
        do_miss("rst_wait");
        reset = 1'b1;
        #2;
        reset = 1'b0;
        {bus.io_ptw_resp_bits_pte_v, bus.io_ptw_resp_bits_pte_u, bus.io_ptw_resp_bits_pte_d} = 3'b111;
        bus.cacheable         = 1'b1;
        bus.io_ptw_resp_valid = 1'b1;
        tick();
        bus.io_ptw_resp_valid = 1'b0;
        check_all_zero("rst_wait");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
